// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words from a register memory and turns
// them into I2C master commands, stopping on HALT or aborting on errors.
module instr_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic [3:0]        mem_error,
  output logic              i2c_cmd_valid,
  input  logic              i2c_cmd_ready,
  output logic              i2c_cmd_rw,
  output logic [7:0]        i2c_dev,
  output logic [7:0]        i2c_reg,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_done,
  input  logic              i2c_ack_err,
  input  logic [7:0]        i2c_rdata,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_RD   = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h03;

  localparam logic [1:0] FC_DECODE = 2'b01;
  localparam logic [1:0] FC_NACK   = 2'b10;
  localparam logic [1:0] FC_END    = 2'b11;

  localparam logic [ADDR_W-1:0] PC_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_LAST  = '1;

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              valid_d, rw_d, rd_valid_d, busy_d, done_d, fault_d;
  logic [7:0]        dev_d, reg_d, wdata_d, rd_data_d;
  logic [1:0]        fault_code_d;
  logic [7:0]        op;

  assign op       = mem_data[31:24];
  assign mem_addr = pc;

  // Next-state and next-output logic; every registered output has a _d here.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    valid_d      = i2c_cmd_valid;
    rw_d         = i2c_cmd_rw;
    dev_d        = i2c_dev;
    reg_d        = i2c_reg;
    wdata_d      = i2c_wdata;
    rd_data_d    = rd_data;
    rd_valid_d   = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = fault_code;

    case (state)
      S_IDLE: begin
        // A start landing on the completion strobe belongs to the old run.
        if (start && !done && !fault) begin
          pc_d         = PC_START;
          fault_code_d = 2'b00;
          busy_d       = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (mem_error != 4'h0) begin
          fault_d      = 1'b1;
          fault_code_d = FC_DECODE;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          case (op)
            OP_NOP: state_d = S_NEXT;
            OP_RD, OP_WR: begin
              rw_d    = (op == OP_RD);
              dev_d   = mem_data[23:16];
              reg_d   = mem_data[15:8];
              wdata_d = mem_data[7:0];
              valid_d = 1'b1;
              state_d = S_ISSUE;
            end
            OP_HALT: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
            default: begin
              fault_d      = 1'b1;
              fault_code_d = FC_DECODE;
              busy_d       = 1'b0;
              state_d      = S_IDLE;
            end
          endcase
        end
      end

      S_ISSUE: begin
        if (i2c_cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            fault_d      = 1'b1;
            fault_code_d = FC_NACK;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            if (i2c_cmd_rw) begin
              rd_data_d  = i2c_rdata;
              rd_valid_d = 1'b1;
            end
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        // Running off the end of memory is an error, never a wrap.
        if (pc == PC_LAST) begin
          fault_d      = 1'b1;
          fault_code_d = FC_END;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          pc_d    = pc + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end

      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pc            <= PC_START;
      i2c_cmd_valid <= 1'b0;
      i2c_cmd_rw    <= 1'b0;
      i2c_dev       <= 8'h00;
      i2c_reg       <= 8'h00;
      i2c_wdata     <= 8'h00;
      rd_data       <= 8'h00;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'b00;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      i2c_cmd_valid <= valid_d;
      i2c_cmd_rw    <= rw_d;
      i2c_dev       <= dev_d;
      i2c_reg       <= reg_d;
      i2c_wdata     <= wdata_d;
      rd_data       <= rd_data_d;
      rd_valid      <= rd_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      fault         <= fault_d;
      fault_code    <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a memory model and I2C responder feed
// the DUT, expected events are queued per program and popped by a monitor.
module tb_instr_sequencer;

  localparam logic [1:0] EV_CMD   = 2'd0;
  localparam logic [1:0] EV_RD    = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_FAULT = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_error;
  logic        i2c_cmd_valid, i2c_cmd_ready, i2c_cmd_rw;
  logic [7:0]  i2c_dev, i2c_reg, i2c_wdata;
  logic        i2c_done, i2c_ack_err;
  logic [7:0]  i2c_rdata, rd_data;
  logic        rd_valid, busy, done, fault;
  logic [1:0]  fault_code;

  logic [31:0] mem [256];
  logic        err_en;
  logic [7:0]  err_addr;
  logic        resp_en;
  int          test_id;
  int          slow_cmd;
  int          err_cmd;
  logic [7:0]  rdata_val;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  instr_sequencer #(.ADDR_W(8), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_error(mem_error), .i2c_cmd_valid(i2c_cmd_valid),
    .i2c_cmd_ready(i2c_cmd_ready), .i2c_cmd_rw(i2c_cmd_rw), .i2c_dev(i2c_dev),
    .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata), .i2c_done(i2c_done),
    .i2c_ack_err(i2c_ack_err), .i2c_rdata(i2c_rdata), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Register memory: data and error code one cycle after the address.
  always @(posedge clk) begin
    mem_data  <= mem[mem_addr];
    mem_error <= (err_en && mem_addr == err_addr) ? 4'h1 : 4'h0;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void expect_ev(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Monitor: every DUT-presented event pops one scoreboard entry.
  always @(negedge clk) begin : monitor
    ev_t obs;
    ev_t e;
    logic have;
    have = 1'b0;
    obs  = '0;
    if (reset) begin
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        obs.kind = EV_CMD; obs.val = {7'b0, i2c_cmd_rw, i2c_dev, i2c_reg, i2c_wdata}; have = 1'b1;
      end else if (rd_valid) begin
        obs.kind = EV_RD; obs.val = {24'b0, rd_data}; have = 1'b1;
      end else if (done) begin
        obs.kind = EV_DONE; obs.val = 32'h0; have = 1'b1;
      end else if (fault) begin
        obs.kind = EV_FAULT; obs.val = {30'b0, fault_code}; have = 1'b1;
      end
    end
    if (have) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: got kind %0d val %0h, required none", obs.kind, obs.val);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(obs.kind), 32'(e.kind));
        check("event_val", obs.val, e.val);
      end
    end
  end

  // I2C responder: ready after slow_cmd's delay, done 4 cycles after transfer.
  initial begin : responder
    int cmd_n;
    int seen_id;
    logic [24:0] cap;
    cmd_n = 0; seen_id = -1;
    i2c_cmd_ready = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (seen_id != test_id) begin cmd_n = 0; seen_id = test_id; end
      if (resp_en && i2c_cmd_valid) begin
        cmd_n++;
        cap = {i2c_cmd_rw, i2c_dev, i2c_reg, i2c_wdata};
        if (cmd_n == slow_cmd) begin
          for (int k = 0; k < 5; k++) begin
            // A stray done during ISSUE must not disturb the sequencer.
            i2c_done    = (k == 0);
            i2c_ack_err = (k == 0);
            check("payload_stable", {7'b0, i2c_cmd_valid, i2c_cmd_rw, i2c_dev, i2c_reg, i2c_wdata},
                  {7'b0, 1'b1, cap});
            @(posedge clk); #1;
          end
          i2c_done = 1'b0; i2c_ack_err = 1'b0;
        end
        i2c_cmd_ready = 1'b1;
        @(posedge clk); #1;
        i2c_cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i2c_done    = 1'b1;
        i2c_ack_err = (cmd_n == err_cmd);
        i2c_rdata   = rdata_val;
        @(posedge clk); #1;
        i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'h00;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic run_prog(input int budget, output logic [7:0] max_a, output bit wrapped);
    int n;
    logic [7:0] prev;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("fault_code_cleared", 32'(fault_code), 32'h0);
    max_a = mem_addr; prev = mem_addr; wrapped = 1'b0; n = 0;
    while (busy && n < budget) begin
      if (mem_addr > max_a) max_a = mem_addr;
      if (mem_addr < prev) wrapped = 1'b1;
      prev = mem_addr;
      @(negedge clk); n++;
    end
    if (busy) begin
      checks++;
      $display("FAIL run_timeout: got busy after %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] max_a;
    bit wrapped;
    int n;
    reset = 1'b0; start = 1'b0; err_en = 1'b0; err_addr = 8'h00;
    resp_en = 1'b1; test_id = 0; slow_cmd = 0; err_cmd = 0; rdata_val = 8'h00;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_outputs", {22'b0, i2c_cmd_valid, busy, done, fault, rd_valid, fault_code, i2c_cmd_rw, 2'b0},
          32'h0);
    check("rst_payload", {i2c_dev, i2c_reg, i2c_wdata, rd_data}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Read, write, halt; extra start mid-run and on the done strobe are ignored.
    test_id = 1; rdata_val = 8'h3C;
    mem[0] = 32'h0100F000; mem[1] = 32'h021DAB32; mem[2] = 32'h03000000;
    expect_ev(EV_CMD, 32'h0100F000); expect_ev(EV_RD, 32'h3C);
    expect_ev(EV_CMD, 32'h001DAB32); expect_ev(EV_DONE, 32'h0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("t1_done_seen", 32'(done), 32'h1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t1_start_on_done_ignored", 32'(busy), 32'h0);
    check("t1_halt_addr", 32'(mem_addr), 32'h2);
    check("t1_no_fault", 32'(fault_code), 32'h0);
    repeat (3) @(negedge clk);

    // Read of 0x5A, then a write held off by ready for 5 cycles.
    test_id = 2; rdata_val = 8'h5A; slow_cmd = 2;
    mem[0] = 32'h01441000; mem[1] = 32'h02441177; mem[2] = 32'h03000000;
    expect_ev(EV_CMD, 32'h01441000); expect_ev(EV_RD, 32'h5A);
    expect_ev(EV_CMD, 32'h00441177); expect_ev(EV_DONE, 32'h0);
    run_prog(300, max_a, wrapped);
    check("t2_rd_data_held", 32'(rd_data), 32'h5A);
    slow_cmd = 0;

    // NACK on the second command aborts before the third fetch.
    test_id = 3; err_cmd = 2;
    mem[0] = 32'h025001AA; mem[1] = 32'h025002BB; mem[2] = 32'h03000000;
    expect_ev(EV_CMD, 32'h005001AA); expect_ev(EV_CMD, 32'h005002BB);
    expect_ev(EV_FAULT, 32'h2);
    run_prog(300, max_a, wrapped);
    check("t3_no_third_fetch", 32'(max_a), 32'h1);
    check("t3_fault_code_held", 32'(fault_code), 32'h2);
    check("t3_busy_low", 32'(busy), 32'h0);
    err_cmd = 0;

    // Illegal opcode at address 1.
    test_id = 4;
    clear_mem(); mem[1] = 32'h07000000;
    expect_ev(EV_FAULT, 32'h1);
    run_prog(100, max_a, wrapped);
    check("t4_fault_code", 32'(fault_code), 32'h1);

    // Memory error at address 1 on an otherwise legal read.
    test_id = 5; err_en = 1'b1; err_addr = 8'h01;
    mem[1] = 32'h01000000;
    expect_ev(EV_FAULT, 32'h1);
    run_prog(100, max_a, wrapped);
    check("t5_fault_code", 32'(fault_code), 32'h1);
    err_en = 1'b0;

    // NOPs all the way to 0xFF: end-of-memory fault, no wrap.
    test_id = 6; clear_mem();
    expect_ev(EV_FAULT, 32'h3);
    run_prog(1000, max_a, wrapped);
    check("t6_fault_code", 32'(fault_code), 32'h3);
    check("t6_max_addr", 32'(max_a), 32'hFF);
    check("t6_no_wrap", 32'(wrapped), 32'h0);
    check("t6_final_addr", 32'(mem_addr), 32'hFF);

    // Reset while a command is offered and never accepted.
    test_id = 7; resp_en = 1'b0;
    mem[0] = 32'h02123456;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!i2c_cmd_valid && n < 20) begin @(negedge clk); n++; end
    check("t7_issue_reached", 32'(i2c_cmd_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t7_valid_async_drop", 32'(i2c_cmd_valid), 32'h0);
    check("t7_busy_async_drop", 32'(busy), 32'h0);
    check("t7_addr_reset", 32'(mem_addr), 32'h0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_no_resume", {30'b0, i2c_cmd_valid, busy}, 32'h0);
    resp_en = 1'b1; rdata_val = 8'hC3; test_id = 8;
    mem[0] = 32'h01112200; mem[1] = 32'h03000000;
    expect_ev(EV_CMD, 32'h01112200); expect_ev(EV_RD, 32'hC3); expect_ev(EV_DONE, 32'h0);
    run_prog(200, max_a, wrapped);
    check("t7_refetch_max_addr", 32'(max_a), 32'h1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
